sensor_input_conditioner: RTL and testbench
===========================================

# sensor_input_conditioner

Front-end conditioning stage between the board's raw sensor pads and controller buttons and the game datapath, which consists of the processor and the VGA game controller. It performs three functions:
- synchronises and debounces 24 sensor lines and 4 active-low controller buttons;
- presents clean, active-high level vectors in the 32-bit word format that the processor and VGA controller already consume;
- queues change events in a small FIFO with a valid/ready handshake, so that software polling cannot miss a short hit.

## Interface

Parameters:
- NUM_SENSORS, 24: used sensor lines, bits [NUM_SENSORS-1:0].
- NUM_BUTTONS, 4: used controller buttons, bits [NUM_BUTTONS-1:0].
- TICK_DIV, 50000: clock cycles per debounce sample tick (1 ms at 50 MHz). Minimum 2.
- STABLE_TICKS, 5: consecutive disagreeing ticks required before a clean bit flips. Minimum 1.
- FIFO_DEPTH, 8: event FIFO entries. Power of 2.

Ports (clock and reset first):
- clock, input, 1: single clock for the whole block.
- reset, input, 1: synchronous, active-high.
- sensor_raw, input, 32: asynchronous pads; upper bits ignored.
- controller_raw, input, 32: asynchronous, active-low buttons; upper bits ignored.
- sensor_clean, output, 32: debounced sensor levels; upper bits are 0.
- controller_clean, output, 32: debounced button levels, active-high (1 = pressed); upper bits are 0.
- sensor_rise, output, 32: one-cycle pulse per bit on a clean 0→1 transition.
- controller_press, output, 32: one-cycle pulse per bit on a clean press.
- evt_valid, output, 1: FIFO head is valid.
- evt_data, output, 6: [4:0] input index (sensors 0..NUM_SENSORS-1, then buttons NUM_SENSORS..NUM_SENSORS+NUM_BUTTONS-1); [5] new level.
- evt_ready, input, 1: consumer accepts the head.
- evt_overflow, output, 1: sticky flag; an event was coalesced.

## Operation

- **Input view.** Internally, channel i is sensor_raw[i] for i < NUM_SENSORS, and ~controller_raw[i-NUM_SENSORS] otherwise, giving N = NUM_SENSORS+NUM_BUTTONS channels.
- **Synchroniser.** Each channel passes through a 2-flop synchroniser. Reset value is 0, i.e. button released.
- **Prescaler.** Counts 0..TICK_DIV-1 and asserts tick when it equals TICK_DIV-1, then wraps to 0.
- **Debounce.** Each channel has a counter of width ceil(log2(STABLE_TICKS+1)). The counter changes only on tick:
  - sync == clean: counter ← 0.
  - sync ≠ clean and counter+1 == STABLE_TICKS: clean ← sync, counter ← 0.
  - otherwise: counter ← counter+1.
- **Edge pulses.** rise/press bits are registered. Each is high only in the first cycle in which the corresponding clean bit shows its new 1 value. Falling edges produce no pulse but do produce events.
- **Pending bitmap.** Any clean transition on channel i sets pending[i].
  - If pending[i] is already set and not being consumed in the same cycle, evt_overflow ← 1, and the events coalesce.
- **Arbiter.** Each cycle, if pending ≠ 0 and the FIFO is not full (or a pop occurs in the same cycle), the lowest-index pending bit is pushed.
  - The pushed entry is {clean[i], i}; the direction is sampled at push time.
  - pending[i] is cleared in the same cycle.
  - If a new edge sets the same bit in that cycle, the set wins and no overflow is raised.
- **FIFO.** Show-ahead. Pop = evt_valid & evt_ready.
  - When full, push and pop in the same cycle are both performed.
  - When empty, evt_ready is ignored.
  - When empty, evt_data holds its last value (0 after reset).
- **Reset values.** While reset is high at a clock edge, all of the following are cleared and held:
  - prescaler, synchronisers, counters, clean vectors, pulses, pending, FIFO pointers and count;
  - evt_valid = 0, evt_data = 0, evt_overflow = 0.

## Timing

- **Raw to clean latency.** A raw step reaches sync after 2 cycles. clean then flips on the STABLE_TICKS-th subsequent tick. Latency is between (STABLE_TICKS-1)·TICK_DIV+3 and STABLE_TICKS·TICK_DIV+2 cycles.
- **Glitches.** A raw glitch that is not sampled as different on STABLE_TICKS consecutive ticks never changes clean.
- **Event latency.** For a single edge with an empty FIFO, evt_valid rises 1 cycle after clean changes.
- **Multiple edges.** k simultaneous edges drain one per cycle in ascending index order.
- **Reset mid-operation.** A partially counted debounce is discarded. Queued events are lost. After reset deasserts, a raw line held high debounces to 1 and produces a normal rise event.

## Test plan

Bench parameters: TICK_DIV=4, STABLE_TICKS=3.

1. **Single sensor step.** Release reset, then at cycle 20 set sensor_raw[5]=1.
   - sensor_clean[5]=1 within 11–14 cycles, with a sensor_rise[5] pulse exactly 1 cycle wide.
   - evt_valid rises the next cycle, with evt_data=6'b1_00101.
2. **Glitch rejection.** Pulse sensor_raw[0] high for 6 cycles.
   - sensor_clean, sensor_rise and evt_valid stay 0.
3. **Button polarity.** Drive controller_raw[2] 1→0.
   - controller_clean[2]=1 and a controller_press[2] pulse occur; the event index is 26 and the level is 1.
   - Releasing the button gives index 26, level 0, and no press pulse.
4. **Simultaneous edges with back-pressure.** Hold evt_ready=0 and step sensors 3, 1 and 10 together.
   - The FIFO holds exactly 3 entries.
   - With evt_ready=1, indices pop in the order 1, 3, 10 on consecutive cycles, then evt_valid=0.
5. **Full FIFO and coalescing.** Hold evt_ready=0 and generate 10 distinct edges.
   - 8 entries are queued and 2 remain pending.
   - Toggling one pending channel twice sets evt_overflow=1.
   - Draining delivers all remaining events. evt_overflow stays 1 until reset.
6. **Reset mid-operation.** Assert reset while a debounce count equals 2 and the FIFO holds 3 entries.
   - Next cycle: all outputs are 0.
   - A raw line held high produces a fresh event after reset releases.

Source files
------------

// File: rtl/sensor_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : sensor_input_conditioner
// Purpose  : Synchronises and debounces raw sensor pads and active-low
//            controller buttons. Presents clean active-high 32-bit level
//            words and one-cycle rise/press pulses. Queues every clean
//            transition in a show-ahead event FIFO with a valid/ready
//            handshake.
// Ports    : clock, reset          - single clock, synchronous active-high reset
//            sensor_raw[31:0]      - asynchronous sensor pads (upper bits unused)
//            controller_raw[31:0]  - asynchronous active-low buttons
//            sensor_clean / controller_clean - debounced levels, zero-extended
//            sensor_rise / controller_press  - one-cycle 0->1 pulses
//            evt_valid / evt_data / evt_ready - event FIFO head, {level, index}
//            evt_overflow          - sticky, set when two events coalesced
// Revision : 1.0 - initial release
// ============================================================================
module sensor_input_conditioner #(
    parameter int NUM_SENSORS  = 24,
    parameter int NUM_BUTTONS  = 4,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 5,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] sensor_raw,
    input  logic [31:0] controller_raw,
    output logic [31:0] sensor_clean,
    output logic [31:0] controller_clean,
    output logic [31:0] sensor_rise,
    output logic [31:0] controller_press,
    output logic        evt_valid,
    output logic [5:0]  evt_data,
    input  logic        evt_ready,
    output logic        evt_overflow
);

    localparam int c_NUM_CH = NUM_SENSORS + NUM_BUTTONS;
    localparam int c_PW     = $clog2(TICK_DIV);
    localparam int c_CW     = $clog2(STABLE_TICKS + 1);
    localparam int c_AW     = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_AW + 1;

    localparam logic [c_PW-1:0]    c_TICK_LAST = c_PW'(TICK_DIV - 1);
    localparam logic [c_CW-1:0]    c_CNT_LAST  = c_CW'(STABLE_TICKS - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH     = c_CNT_W'(FIFO_DEPTH);

    // Channel view: sensors in the low indices, inverted buttons above them.
    logic [c_NUM_CH-1:0] w_raw;
    logic                w_unused;
    assign w_raw    = {~controller_raw[NUM_BUTTONS-1:0], sensor_raw[NUM_SENSORS-1:0]};
    assign w_unused = ^{sensor_raw, controller_raw};

    logic [c_NUM_CH-1:0] r_sync1;
    logic [c_NUM_CH-1:0] r_sync2;
    logic [c_PW-1:0]     r_presc;
    logic                w_tick;
    logic [c_CW-1:0]     r_cnt [c_NUM_CH];
    logic [c_NUM_CH-1:0] r_clean;
    logic [c_NUM_CH-1:0] w_flip;
    logic [c_NUM_CH-1:0] r_rise;
    logic [c_NUM_CH-1:0] r_pending;
    logic                r_overflow;

    logic [c_NUM_CH-1:0] w_lowest;
    logic [c_NUM_CH-1:0] w_grant;
    logic [4:0]          w_sel_idx;
    logic                w_sel_level;
    logic                w_push;
    logic [5:0]          w_push_data;

    logic [5:0]          r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]     r_wr_ptr;
    logic [c_AW-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [5:0]          r_evt_data;
    logic                w_pop;
    logic [c_AW-1:0]     w_rd_next;
    logic [c_CNT_W-1:0]  w_cnt_after_pop;

    // ------------------------------------------------------------------
    // Synchroniser and debounce sample prescaler
    // ------------------------------------------------------------------
    assign w_tick = (r_presc == c_TICK_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_presc <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_presc <= w_tick ? '0 : r_presc + c_PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Debounce: a bit flips on the tick where its disagreement count
    // would reach STABLE_TICKS.
    // ------------------------------------------------------------------
    always_comb begin
        w_flip = '0;
        for (int i = 0; i < c_NUM_CH; i++) begin
            w_flip[i] = w_tick && (r_sync2[i] != r_clean[i]) && (r_cnt[i] == c_CNT_LAST);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < c_NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
            r_clean <= '0;
            r_rise  <= '0;
        end else begin
            if (w_tick) begin
                for (int i = 0; i < c_NUM_CH; i++) begin
                    if ((r_sync2[i] == r_clean[i]) || w_flip[i]) begin
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + c_CW'(1);
                    end
                end
            end
            r_clean <= r_clean ^ w_flip;
            // Registered alongside clean, so the pulse coincides with the
            // first cycle the new 1 is visible.
            r_rise  <= w_flip & r_sync2;
        end
    end

    // ------------------------------------------------------------------
    // Arbiter: lowest pending index wins; a pop frees a slot this cycle.
    // ------------------------------------------------------------------
    assign w_pop           = (r_count != '0) && evt_ready;
    assign w_rd_next       = r_rd_ptr + c_AW'(w_pop);
    assign w_cnt_after_pop = r_count - c_CNT_W'(w_pop);

    always_comb begin
        w_lowest    = '0;
        w_sel_idx   = '0;
        w_sel_level = 1'b0;
        // Descending scan so the last hit is the lowest index.
        for (int i = c_NUM_CH - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_lowest    = '0;
                w_lowest[i] = 1'b1;
                w_sel_idx   = 5'(i);
                w_sel_level = r_clean[i];
            end
        end
        w_push      = (|r_pending) && ((r_count != c_DEPTH) || w_pop);
        w_grant     = w_push ? w_lowest : '0;
        w_push_data = {w_sel_level, w_sel_idx};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            // A new edge on a bit being granted re-arms it without overflow.
            r_pending <= (r_pending & ~w_grant) | w_flip;
            if (|(w_flip & r_pending & ~w_grant)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO; the head is registered so it holds while empty.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_evt_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_cnt_after_pop + c_CNT_W'(w_push);
            if (w_push && (w_cnt_after_pop == '0)) begin
                r_evt_data <= w_push_data;
            end else if (w_cnt_after_pop != '0) begin
                r_evt_data <= r_mem[w_rd_next];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sensor_clean     = 32'(r_clean[NUM_SENSORS-1:0]);
    assign controller_clean = 32'(r_clean[c_NUM_CH-1:NUM_SENSORS]);
    assign sensor_rise      = 32'(r_rise[NUM_SENSORS-1:0]);
    assign controller_press = 32'(r_rise[c_NUM_CH-1:NUM_SENSORS]);
    assign evt_valid        = (r_count != '0);
    assign evt_data         = r_evt_data;
    assign evt_overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_sensor_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_input_conditioner
// Purpose  : Self-checking bench for sensor_input_conditioner with
//            TICK_DIV=4, STABLE_TICKS=3. Expected events are queued when
//            stimulus is driven and compared as the DUT hands them out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_input_conditioner;

    localparam int c_TICK_DIV = 4;
    localparam int c_STABLE   = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] sensor_raw;
    logic [31:0] controller_raw;
    logic [31:0] sensor_clean;
    logic [31:0] controller_clean;
    logic [31:0] sensor_rise;
    logic [31:0] controller_press;
    logic        evt_valid;
    logic [5:0]  evt_data;
    logic        evt_ready;
    logic        evt_overflow;

    int          checks = 0;
    int          errors = 0;
    logic [5:0]  exp_q [$];
    logic [5:0]  mon_exp;

    always #5 clock = ~clock;

    sensor_input_conditioner #(
        .NUM_SENSORS  (24),
        .NUM_BUTTONS  (4),
        .TICK_DIV     (c_TICK_DIV),
        .STABLE_TICKS (c_STABLE),
        .FIFO_DEPTH   (8)
    ) u_dut (
        .clock            (clock),
        .reset            (reset),
        .sensor_raw       (sensor_raw),
        .controller_raw   (controller_raw),
        .sensor_clean     (sensor_clean),
        .controller_clean (controller_clean),
        .sensor_rise      (sensor_rise),
        .controller_press (controller_press),
        .evt_valid        (evt_valid),
        .evt_data         (evt_data),
        .evt_ready        (evt_ready),
        .evt_overflow     (evt_overflow)
    );

    // Scoreboard: every handshake is compared against the queue head.
    always @(negedge clock) begin
        if (!reset && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL evt_unexpected got=%b expected=none", evt_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (evt_data !== mon_exp) begin
                    errors++;
                    $display("FAIL evt_data got=%b expected=%b", evt_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset          = 1'b1;
        sensor_raw     = '0;
        controller_raw = '1;
        evt_ready      = 1'b1;
        cyc(3);
        checks++; if (sensor_clean !== 32'h0) begin errors++; $display("FAIL rst_sensor_clean got=%h expected=0", sensor_clean); end
        checks++; if (controller_clean !== 32'h0) begin errors++; $display("FAIL rst_controller_clean got=%h expected=0", controller_clean); end
        checks++; if ((sensor_rise | controller_press) !== 32'h0) begin errors++; $display("FAIL rst_pulses got=%h expected=0", sensor_rise | controller_press); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rst_evt_valid got=%b expected=0", evt_valid); end
        checks++; if (evt_data !== 6'd0) begin errors++; $display("FAIL rst_evt_data got=%b expected=0", evt_data); end
        checks++; if (evt_overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got=%b expected=0", evt_overflow); end
        reset = 1'b0;
    endtask

    task automatic test_single_step;
        int lat;
        cyc(20);
        sensor_raw[5] = 1'b1;
        exp_q.push_back(6'b1_00101);
        lat = 0;
        while (sensor_clean[5] !== 1'b1 && lat < 30) begin
            cyc(1);
            lat++;
        end
        checks++; if (lat < 11 || lat > 14) begin errors++; $display("FAIL step_latency got=%0d expected=11..14", lat); end
        checks++; if (sensor_rise !== 32'h20) begin errors++; $display("FAIL step_rise_on got=%h expected=00000020", sensor_rise); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL step_valid_early got=%b expected=0", evt_valid); end
        cyc(1);
        checks++; if (sensor_rise !== 32'h0) begin errors++; $display("FAIL step_rise_off got=%h expected=0", sensor_rise); end
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL step_valid got=%b expected=1", evt_valid); end
        checks++; if (evt_data !== 6'b1_00101) begin errors++; $display("FAIL step_data got=%b expected=100101", evt_data); end
        cyc(1);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL step_drained got=%b expected=0", evt_valid); end
        checks++; if (evt_data !== 6'b1_00101) begin errors++; $display("FAIL step_data_hold got=%b expected=100101", evt_data); end
    endtask

    task automatic test_glitch;
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 36; i++) begin
            sensor_raw[0] = (i < 6);
            cyc(1);
            if (sensor_clean[0] !== 1'b0 || sensor_rise !== 32'h0 || evt_valid !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL glitch_seen got=%b expected=0", bad); end
    endtask

    task automatic test_button;
        int   lat;
        logic saw_press;
        controller_raw[2] = 1'b0;
        exp_q.push_back(6'b1_11010);
        lat = 0;
        while (controller_clean[2] !== 1'b1 && lat < 30) begin cyc(1); lat++; end
        checks++; if (controller_clean !== 32'h4) begin errors++; $display("FAIL btn_clean got=%h expected=00000004", controller_clean); end
        checks++; if (controller_press !== 32'h4) begin errors++; $display("FAIL btn_press got=%h expected=00000004", controller_press); end
        cyc(1);
        checks++; if (controller_press !== 32'h0) begin errors++; $display("FAIL btn_press_off got=%h expected=0", controller_press); end
        cyc(3);
        controller_raw[2] = 1'b1;
        exp_q.push_back(6'b0_11010);
        lat = 0;
        saw_press = 1'b0;
        while (controller_clean[2] !== 1'b0 && lat < 30) begin
            cyc(1);
            lat++;
            if (controller_press !== 32'h0) saw_press = 1'b1;
        end
        checks++; if (lat >= 30) begin errors++; $display("FAIL btn_release_timeout got=%0d expected<30", lat); end
        checks++; if (saw_press !== 1'b0) begin errors++; $display("FAIL btn_release_press got=%b expected=0", saw_press); end
        cyc(3);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL btn_events_left got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_back_to_back;
        int lat;
        int n;
        evt_ready     = 1'b0;
        sensor_raw[1] = 1'b1;
        sensor_raw[3] = 1'b1;
        sensor_raw[10] = 1'b1;
        exp_q.push_back(6'b1_00001);
        exp_q.push_back(6'b1_00011);
        exp_q.push_back(6'b1_01010);
        lat = 0;
        while ((sensor_clean & 32'h40A) !== 32'h40A && lat < 30) begin cyc(1); lat++; end
        cyc(6);
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL b2b_held got=%b expected=1", evt_valid); end
        evt_ready = 1'b1;
        n = 0;
        while (evt_valid === 1'b1 && n < 20) begin n++; cyc(1); end
        checks++; if (n != 3) begin errors++; $display("FAIL b2b_count got=%0d expected=3", n); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_events_left got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_full_coalesce;
        int lat;
        int n;
        evt_ready         = 1'b0;
        sensor_raw[20:11] = '1;
        for (int i = 11; i <= 20; i++) exp_q.push_back({1'b1, 5'(i)});
        lat = 0;
        while (sensor_clean[20:11] !== 10'h3FF && lat < 30) begin cyc(1); lat++; end
        cyc(12);
        checks++; if (evt_overflow !== 1'b0) begin errors++; $display("FAIL full_ovf_early got=%b expected=0", evt_overflow); end
        sensor_raw[20] = 1'b0;
        lat = 0;
        while (sensor_clean[20] !== 1'b0 && lat < 30) begin cyc(1); lat++; end
        checks++; if (evt_overflow !== 1'b1) begin errors++; $display("FAIL full_ovf_set got=%b expected=1", evt_overflow); end
        sensor_raw[20] = 1'b1;
        lat = 0;
        while (sensor_clean[20] !== 1'b1 && lat < 30) begin cyc(1); lat++; end
        cyc(2);
        evt_ready = 1'b1;
        n = 0;
        while (evt_valid === 1'b1 && n < 30) begin n++; cyc(1); end
        checks++; if (n != 10) begin errors++; $display("FAIL full_drain_count got=%0d expected=10", n); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_events_left got=%0d expected=0", exp_q.size()); end
        checks++; if (evt_overflow !== 1'b1) begin errors++; $display("FAIL full_ovf_sticky got=%b expected=1", evt_overflow); end
    endtask

    task automatic test_reset_mid;
        int lat;
        evt_ready         = 1'b0;
        sensor_raw[23:21] = '1;
        lat = 0;
        while (sensor_clean[23] !== 1'b1 && lat < 30) begin cyc(1); lat++; end
        // Just past a tick edge: two counted ticks for sensor 0 take 8 cycles.
        sensor_raw[0] = 1'b1;
        cyc(8);
        checks++; if (evt_valid !== 1'b1 || sensor_clean[0] !== 1'b0) begin errors++; $display("FAIL mid_pre_state got=%b%b expected=10", evt_valid, sensor_clean[0]); end
        reset = 1'b1;
        cyc(1);
        checks++; if ((sensor_clean | controller_clean | sensor_rise | controller_press) !== 32'h0) begin errors++; $display("FAIL mid_rst_vectors got=%h expected=0", sensor_clean | controller_clean); end
        checks++; if ({evt_valid, evt_data, evt_overflow} !== 8'h0) begin errors++; $display("FAIL mid_rst_evt got=%b expected=0", {evt_valid, evt_data, evt_overflow}); end
        exp_q.delete();
        cyc(1);
        reset     = 1'b0;
        evt_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (sensor_raw[i]) exp_q.push_back({1'b1, 5'(i)});
        end
        lat = 0;
        while (exp_q.size() != 0 && lat < 100) begin cyc(1); lat++; end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_events_left got=%0d expected=0", exp_q.size()); end
        checks++; if (sensor_clean !== (sensor_raw & 32'h00FF_FFFF)) begin errors++; $display("FAIL mid_clean got=%h expected=%h", sensor_clean, sensor_raw & 32'h00FF_FFFF); end
        checks++; if (evt_overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got=%b expected=0", evt_overflow); end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_glitch();
        test_button();
        test_back_to_back();
        test_full_coalesce();
        test_reset_mid();
        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
